// File: rtl/usb_proto_ctrl.sv
// ============================================================================
// Module   : usb_proto_ctrl
// Brief    : USB full-speed device endpoint transaction sequencer (OUT/IN
//            handshakes, buffer direction/flush, sticky status flags).
//            Optional macro NAK_ON_FULL_EN: NAK OUT tokens while rx_done set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module usb_proto_ctrl #(
    parameter int TIMEOUT_CYCLES = 816,
    parameter int BUF_DEPTH      = 64
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic [2:0]                       rx_packet,
    input  logic                             rx_data_ready,
    input  logic                             rx_transfer_active,
    input  logic                             rx_error,
    input  logic                             tx_transfer_active,
    input  logic                             tx_error,
    input  logic [$clog2(BUF_DEPTH+1)-1:0]   buffer_occupancy,
    input  logic                             host_tx_ready,
    input  logic                             host_clear,
    output logic [2:0]                       tx_packet,
    output logic                             d_mode,
    output logic                             flush,
    output logic                             rx_done,
    output logic                             tx_done,
    output logic                             ctrl_error,
    output logic                             busy
);

    localparam int              c_CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_PID_OUT  = 3'd1;
    localparam logic [2:0] c_PID_IN   = 3'd2;
    localparam logic [2:0] c_PID_DATA = 3'd3;
    localparam logic [2:0] c_PID_ACK  = 3'd4;

    localparam logic [2:0] c_TX_NONE  = 3'd0;
    localparam logic [2:0] c_TX_DATA  = 3'd1;
    localparam logic [2:0] c_TX_ACK   = 3'd2;
    localparam logic [2:0] c_TX_NAK   = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OUT_WAIT  = 3'd1,
        S_OUT_HS    = 3'd2,
        S_IN_SEND   = 3'd3,
        S_IN_TXWAIT = 3'd4,
        S_IN_HSWAIT = 3'd5,
        S_TX_WAIT   = 3'd6
    } state_t;

    state_t               r_state;
    logic [2:0]           r_tx_packet;
    logic                 r_d_mode;
    logic                 r_flush;
    logic                 r_rx_done;
    logic                 r_tx_done;
    logic                 r_ctrl_error;
    logic                 r_busy;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_tx_act_q;

    logic                 w_tx_fall;
    logic                 w_rx_ok;
    logic                 w_unused;

    assign w_tx_fall = r_tx_act_q & ~tx_transfer_active;
    assign w_rx_ok   = rx_data_ready & ~rx_error;
    // RX activity is not needed: decisions are made on completed packets only.
    assign w_unused  = rx_transfer_active;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_tx_packet  <= c_TX_NONE;
            r_d_mode     <= 1'b0;
            r_flush      <= 1'b0;
            r_rx_done    <= 1'b0;
            r_tx_done    <= 1'b0;
            r_ctrl_error <= 1'b0;
            r_busy       <= 1'b0;
            r_cnt        <= '0;
            r_tx_act_q   <= 1'b0;
        end else begin
            r_tx_packet <= c_TX_NONE;
            r_flush     <= 1'b0;
            r_tx_act_q  <= tx_transfer_active;

            // Clear first so that a same-cycle set event below takes priority.
            if (host_clear) begin
                r_rx_done    <= 1'b0;
                r_tx_done    <= 1'b0;
                r_ctrl_error <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rx_ok && rx_packet == c_PID_OUT) begin
`ifdef NAK_ON_FULL_EN
                        if (r_rx_done) begin
                            r_tx_packet <= c_TX_NAK;
                            r_state     <= S_TX_WAIT;
                            r_busy      <= 1'b1;
                        end else begin
                            r_flush  <= 1'b1;
                            r_d_mode <= 1'b0;
                            r_state  <= S_OUT_WAIT;
                            r_busy   <= 1'b1;
                        end
`else
                        r_flush  <= 1'b1;
                        r_d_mode <= 1'b0;
                        r_state  <= S_OUT_WAIT;
                        r_busy   <= 1'b1;
`endif
                    end else if (w_rx_ok && rx_packet == c_PID_IN) begin
                        if (host_tx_ready && buffer_occupancy != '0) begin
                            r_d_mode <= 1'b1;
                            r_state  <= S_IN_SEND;
                        end else begin
                            r_tx_packet <= c_TX_NAK;
                            r_state     <= S_TX_WAIT;
                        end
                        r_busy <= 1'b1;
                    end
                end

                S_OUT_WAIT: begin
                    if (rx_data_ready) begin
                        if (!rx_error && rx_packet == c_PID_DATA) begin
                            r_tx_packet <= c_TX_ACK;
                            r_rx_done   <= 1'b1;
                            r_state     <= S_TX_WAIT;
                        end else begin
                            // Corrupt payload is discarded silently; host retries.
                            r_flush      <= 1'b1;
                            r_ctrl_error <= 1'b1;
                            r_state      <= S_IDLE;
                            r_busy       <= 1'b0;
                        end
                    end
                end

                S_IN_SEND: begin
                    r_tx_packet <= c_TX_DATA;
                    r_state     <= S_IN_TXWAIT;
                end

                S_IN_TXWAIT: begin
                    if (tx_error) begin
                        r_ctrl_error <= 1'b1;
                        r_d_mode     <= 1'b0;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else if (w_tx_fall) begin
                        r_cnt   <= '0;
                        r_state <= S_IN_HSWAIT;
                    end
                end

                S_IN_HSWAIT: begin
                    if (rx_data_ready) begin
                        if (!rx_error && rx_packet == c_PID_ACK) begin
                            r_flush   <= 1'b1;
                            r_tx_done <= 1'b1;
                        end else begin
                            r_ctrl_error <= 1'b1;
                        end
                        r_d_mode <= 1'b0;
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end else if (r_cnt == c_TMO_LAST) begin
                        // Payload stays in the buffer so the host can retry the IN.
                        r_ctrl_error <= 1'b1;
                        r_d_mode     <= 1'b0;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end

                S_TX_WAIT: begin
                    if (tx_error) begin
                        r_ctrl_error <= 1'b1;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else if (w_tx_fall) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_d_mode <= 1'b0;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_packet  = r_tx_packet;
    assign d_mode     = r_d_mode;
    assign flush      = r_flush;
    assign rx_done    = r_rx_done;
    assign tx_done    = r_tx_done;
    assign ctrl_error = r_ctrl_error;
    assign busy       = r_busy;

endmodule

`default_nettype wire
